// File: rtl/cai_submit_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cai_submit_sched
// Brief    : Round-robin scheduler sharing one CAI host submit port among
//            N_REQ requesters; rings the doorbell after a stable-config cycle
//            and waits for comp_irq. Completion watchdog is built only when
//            CARBON_CAI_SCHED_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cai_submit_sched #(
    parameter int N_REQ          = 4,
    parameter int ADDR_W         = 64,
    parameter int RING_W         = 32,
    parameter int CTX_W          = 16,
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ADDR_W-1:0] req_base,
    input  logic [N_REQ*RING_W-1:0] req_size,
    input  logic [N_REQ*CTX_W-1:0]  req_ctx,
    output logic [ADDR_W-1:0]       submit_base,
    output logic [RING_W-1:0]       submit_size,
    output logic [CTX_W-1:0]        context_sel,
    output logic                    submit_doorbell,
    input  logic                    comp_irq,
    output logic                    done_valid,
    output logic [ID_W-1:0]         done_id,
    output logic                    done_err,
    output logic                    busy
);

    localparam int c_PTR_W = $clog2(N_REQ);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RING  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             r_state, w_state_nx;
    logic [c_PTR_W-1:0] r_ptr, w_ptr_nx;
    logic [N_REQ-1:0]   r_ready, w_ready_nx;
    logic [ADDR_W-1:0]  r_base, w_base_nx;
    logic [RING_W-1:0]  r_size, w_size_nx;
    logic [CTX_W-1:0]   r_ctx, w_ctx_nx;
    logic               r_doorbell, w_doorbell_nx;
    logic               r_done_valid, w_done_valid_nx;
    logic [ID_W-1:0]    r_done_id, w_done_id_nx;
    logic               r_done_err, w_done_err_nx;
    logic               r_busy, w_busy_nx;

    logic               w_any;
    logic [c_PTR_W-1:0] w_winner;
    logic [c_PTR_W-1:0] w_idx;
    logic               w_wd_term;

    logic [ADDR_W-1:0]  w_base_arr [N_REQ];
    logic [RING_W-1:0]  w_size_arr [N_REQ];
    logic [CTX_W-1:0]   w_ctx_arr  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_base_arr[g] = req_base[g*ADDR_W +: ADDR_W];
        assign w_size_arr[g] = req_size[g*RING_W +: RING_W];
        assign w_ctx_arr[g]  = req_ctx[g*CTX_W +: CTX_W];
    end

`ifdef CARBON_CAI_SCHED_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WD_W-1:0] r_wd_cnt;

    // Counts silent WAIT cycles; any other state re-arms it for the next job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wd_cnt <= '0;
        end else if (!comp_irq) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_wd_term = (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_wd_term        = 1'b0;
`endif

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = c_PTR_W'((32'(r_ptr) + 32'(k)) % N_REQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_ptr_nx        = r_ptr;
        w_ready_nx      = '0;
        w_base_nx       = r_base;
        w_size_nx       = r_size;
        w_ctx_nx        = r_ctx;
        w_doorbell_nx   = 1'b0;
        w_done_valid_nx = 1'b0;
        w_done_id_nx    = r_done_id;
        w_done_err_nx   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nx           = ST_SETUP;
                    w_ready_nx[w_winner] = 1'b1;
                    w_base_nx            = w_base_arr[w_winner];
                    w_size_nx            = w_size_arr[w_winner];
                    w_ctx_nx             = w_ctx_arr[w_winner];
                    w_done_id_nx         = ID_W'(w_winner);
                    w_ptr_nx             = (w_winner == c_PTR_W'(N_REQ - 1)) ? '0
                                                                             : w_winner + 1'b1;
                end
            end
            ST_SETUP: begin
                w_state_nx = ST_RING;
            end
            // A zero-size job suppresses the doorbell and completes with an
            // error two cycles after its accept pulse.
            ST_RING: begin
                if (r_size == '0) begin
                    w_state_nx      = ST_DONE;
                    w_done_valid_nx = 1'b1;
                    w_done_err_nx   = 1'b1;
                end else begin
                    w_state_nx    = ST_WAIT;
                    w_doorbell_nx = 1'b1;
                end
            end
            ST_WAIT: begin
                if (comp_irq) begin
                    w_state_nx      = ST_DONE;
                    w_done_valid_nx = 1'b1;
                end else if (w_wd_term) begin
                    w_state_nx      = ST_DONE;
                    w_done_valid_nx = 1'b1;
                    w_done_err_nx   = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign w_busy_nx = (w_state_nx != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_ready      <= '0;
            r_base       <= '0;
            r_size       <= '0;
            r_ctx        <= '0;
            r_doorbell   <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_id    <= '0;
            r_done_err   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_ptr        <= w_ptr_nx;
            r_ready      <= w_ready_nx;
            r_base       <= w_base_nx;
            r_size       <= w_size_nx;
            r_ctx        <= w_ctx_nx;
            r_doorbell   <= w_doorbell_nx;
            r_done_valid <= w_done_valid_nx;
            r_done_id    <= w_done_id_nx;
            r_done_err   <= w_done_err_nx;
            r_busy       <= w_busy_nx;
        end
    end

    assign req_ready       = r_ready;
    assign submit_base     = r_base;
    assign submit_size     = r_size;
    assign context_sel     = r_ctx;
    assign submit_doorbell = r_doorbell;
    assign done_valid      = r_done_valid;
    assign done_id         = r_done_id;
    assign done_err        = r_done_err;
    assign busy            = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_cai_submit_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cai_submit_sched
// Brief    : Scoreboard bench for cai_submit_sched; grants, doorbell configs
//            and completions are queued at stimulus time and popped on output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cai_submit_sched;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 64;
    localparam int RING_W = 32;
    localparam int CTX_W  = 16;
    localparam int ID_W   = 4;

    logic                                clk = 1'b0;
    logic                                rst;
    logic [N_REQ-1:0]                    req_valid;
    logic [N_REQ-1:0]                    req_ready;
    logic [N_REQ-1:0][ADDR_W-1:0]        req_base;
    logic [N_REQ-1:0][RING_W-1:0]        req_size;
    logic [N_REQ-1:0][CTX_W-1:0]         req_ctx;
    logic [ADDR_W-1:0]                   submit_base;
    logic [RING_W-1:0]                   submit_size;
    logic [CTX_W-1:0]                    context_sel;
    logic                                submit_doorbell;
    logic                                comp_irq;
    logic                                done_valid;
    logic [ID_W-1:0]                     done_id;
    logic                                done_err;
    logic                                busy;

    cai_submit_sched #(
        .N_REQ          (N_REQ),
        .ADDR_W         (ADDR_W),
        .RING_W         (RING_W),
        .CTX_W          (CTX_W),
        .ID_W           (ID_W),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_base        (req_base),
        .req_size        (req_size),
        .req_ctx         (req_ctx),
        .submit_base     (submit_base),
        .submit_size     (submit_size),
        .context_sel     (context_sel),
        .submit_doorbell (submit_doorbell),
        .comp_irq        (comp_irq),
        .done_valid      (done_valid),
        .done_id         (done_id),
        .done_err        (done_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int           n_chk  = 0;
    int           n_pass = 0;
    int           cyc_n  = 0;
    int           t_ready = 0, t_db = 0, t_done = 0, t_irq = 0;
    int           n_db = 0, n_done = 0;
    bit           hold_all = 1'b0;
    int           exp_grant [$];
    logic [127:0] exp_cfg   [$];
    logic [4:0]   exp_done  [$];
    logic [127:0] prev_cfg = '0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] pack_cfg(input logic [63:0] b, input logic [31:0] s,
                                              input logic [15:0] c);
        return {16'h0, b, s, c};
    endfunction

    // One cycle: sample at the falling edge and score whatever the DUT emitted.
    task automatic step();
        logic [127:0] cur;
        logic [4:0]   d;
        int           g;
        @(negedge clk);
        cyc_n++;
        cur = pack_cfg(submit_base, submit_size, context_sel);
        if (req_ready != '0) begin
            t_ready = cyc_n;
            check_eq("busy_at_accept", busy, 1);
            if (exp_grant.size() == 0) begin
                check_eq("extra_grant", req_ready, 0);
            end else begin
                g = exp_grant.pop_front();
                check_eq("grant", req_ready, 128'(1) << g);
            end
            if (!hold_all) req_valid = req_valid & ~req_ready;
        end
        if (submit_doorbell) begin
            t_db = cyc_n;
            n_db++;
            check_eq("cfg_stable", cur, prev_cfg);
            if (exp_cfg.size() == 0) check_eq("extra_doorbell", submit_doorbell, 0);
            else check_eq("doorbell_cfg", cur, exp_cfg.pop_front());
        end
        if (done_valid) begin
            t_done = cyc_n;
            n_done++;
            check_eq("busy_at_done", busy, 1);
            if (exp_done.size() == 0) begin
                check_eq("extra_done", done_valid, 0);
            end else begin
                d = exp_done.pop_front();
                check_eq("done_err_id", {done_err, done_id}, d);
            end
        end
        prev_cfg = cur;
    endtask

    task automatic post(input logic [1:0] i, input logic [63:0] b, input logic [31:0] s,
                        input logic [15:0] c);
        req_base[i]  = b;
        req_size[i]  = s;
        req_ctx[i]   = c;
        req_valid[i] = 1'b1;
    endtask

    // Runs until n_jobs completions; comp_irq is returned irq_dly cycles after
    // each doorbell (irq_dly < 0: never).
    task automatic run_jobs(input string tag, input int n_jobs, input int irq_dly,
                            input int budget);
        int n0 = n_done;
        t_db = -1000;
        for (int i = 0; i < budget && (n_done - n0) < n_jobs; i++) begin
            step();
            comp_irq = (irq_dly >= 0) && (cyc_n == t_db + irq_dly);
            if (comp_irq) t_irq = cyc_n;
        end
        comp_irq = 1'b0;
        check_eq(tag, n_done - n0, n_jobs);
    endtask

    initial begin
        int n0;
        int tr0;
        rst       = 1'b1;
        req_valid = '0;
        req_base  = '0;
        req_size  = '0;
        req_ctx   = '0;
        comp_irq  = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_submit_base", submit_base, 0);
        check_eq("rst_submit_size", submit_size, 0);
        check_eq("rst_context_sel", context_sel, 0);
        check_eq("rst_doorbell", submit_doorbell, 0);
        check_eq("rst_done_valid", done_valid, 0);
        check_eq("rst_done_id", done_id, 0);
        check_eq("rst_done_err", done_err, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2) step();

        // Single request from requester 2.
        post(2'd2, 64'h1000, 32'd64, 16'd5);
        exp_grant.push_back(2);
        exp_cfg.push_back(pack_cfg(64'h1000, 32'd64, 16'd5));
        exp_done.push_back({1'b0, 4'd2});
        run_jobs("single_done", 1, 4, 40);
        check_eq("single_db_lat", t_db - t_ready, 2);
        check_eq("single_done_lat", t_done - t_ready, 7);
        check_eq("single_irq_to_done", t_done - t_irq, 1);

        // Interrupts while idle are ignored; config stays at the last job.
        n0 = n_done;
        comp_irq = 1'b1;
        repeat (3) step();
        comp_irq = 1'b0;
        check_eq("idle_irq_ignored", n_done - n0, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("cfg_held_base", submit_base, 64'h1000);
        check_eq("cfg_held_ctx", context_sel, 16'd5);

        // Zero-size job: error completion, no doorbell.
        n0 = n_db;
        post(2'd1, 64'h3000, 32'd0, 16'd9);
        exp_grant.push_back(1);
        exp_done.push_back({1'b1, 4'd1});
        run_jobs("zero_done", 1, -1, 40);
        check_eq("zero_done_lat", t_done - t_ready, 2);
        check_eq("zero_no_doorbell", n_db - n0, 0);

        // Stale interrupt high through SETUP and RING must not complete the job.
        step();
        n0  = n_done;
        tr0 = t_ready;
        post(2'd3, 64'hABCD_0000, 32'd128, 16'h0033);
        exp_grant.push_back(3);
        exp_cfg.push_back(pack_cfg(64'hABCD_0000, 32'd128, 16'h0033));
        exp_done.push_back({1'b0, 4'd3});
        for (int i = 0; i < 20 && t_ready == tr0; i++) step();
        check_eq("stale_accepted", t_ready != tr0, 1);
        comp_irq = 1'b1;
        step();
        step();
        comp_irq = 1'b0;
        check_eq("stale_db_lat", t_db - t_ready, 2);
        repeat (6) step();
        check_eq("stale_ignored", n_done - n0, 0);
        comp_irq = 1'b1;
        t_irq    = cyc_n;
        step();
        comp_irq = 1'b0;
        check_eq("stale_done", n_done - n0, 1);
        check_eq("stale_done_lat", t_done - t_irq, 1);
        step();

        // Reset asserted during the doorbell cycle abandons the job.
        n0  = n_db;
        tr0 = n_done;
        post(2'd2, 64'h2222_0000, 32'd16, 16'h0007);
        exp_grant.push_back(2);
        exp_cfg.push_back(pack_cfg(64'h2222_0000, 32'd16, 16'h0007));
        for (int i = 0; i < 20 && n_db == n0; i++) step();
        check_eq("rst_job_doorbell", n_db - n0, 1);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_async_doorbell", submit_doorbell, 0);
        check_eq("rst_async_busy", busy, 0);
        check_eq("rst_async_base", submit_base, 0);
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        check_eq("rst_no_done", n_done - tr0, 0);

        // After reset requester 0 outranks requester 3.
        post(2'd0, 64'h4000, 32'd32, 16'd1);
        post(2'd3, 64'h7000, 32'd48, 16'd4);
        exp_grant.push_back(0);
        exp_grant.push_back(3);
        exp_cfg.push_back(pack_cfg(64'h4000, 32'd32, 16'd1));
        exp_cfg.push_back(pack_cfg(64'h7000, 32'd48, 16'd4));
        exp_done.push_back({1'b0, 4'd0});
        exp_done.push_back({1'b0, 4'd3});
        run_jobs("post_rst_done", 2, 3, 60);
        step();

        // Round-robin with all requesters held valid: 0,1,2,3,0.
        hold_all = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            post(2'(i), 64'h1_0000 * (i + 1), 32'd8 * (i + 1), 16'(16'h10 + i));
        end
        for (int j = 0; j < 5; j++) begin
            exp_grant.push_back(j % N_REQ);
            exp_cfg.push_back(pack_cfg(64'h1_0000 * ((j % N_REQ) + 1), 32'd8 * ((j % N_REQ) + 1),
                                       16'(16'h10 + (j % N_REQ))));
            exp_done.push_back({1'b0, 4'(j % N_REQ)});
        end
        run_jobs("rr_done", 5, 3, 200);
        req_valid = '0;
        hold_all  = 1'b0;
        repeat (3) step();

`ifdef CARBON_CAI_SCHED_TIMEOUT_EN
        // Silent device: watchdog completes the job 8 WAIT cycles in.
        post(2'd1, 64'h9000, 32'd8, 16'd2);
        exp_grant.push_back(1);
        exp_cfg.push_back(pack_cfg(64'h9000, 32'd8, 16'd2));
        exp_done.push_back({1'b1, 4'd1});
        run_jobs("timeout_done", 1, -1, 60);
        check_eq("timeout_lat", t_done - t_db, 8);
        repeat (2) step();
`endif

        check_eq("sb_drained", exp_grant.size() + exp_cfg.size() + exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cai_submit_sched.md
Name: cai_submit_sched

Overview:
- Host-side scheduler that shares one CAI host port among N_REQ requesters (CPU cores, DMA agents).
- Arbitrates submit requests round-robin and drives the CAI submit ring registers and context select.
- Pulses the submit doorbell only after the config has been stable for one cycle, then waits for the completion interrupt before serving the next request.
- Sits between the requester fabric and the CAI host-modport signal group.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ADDR_W, 64, submit ring base width.
- RING_W, 32, submit ring size width.
- CTX_W, 16, context select width.
- ID_W, 4, width of grant/done index; must be >= clog2(N_REQ).
- TIMEOUT_CYCLES, 4096, completion watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  per-requester submit request, level; held until accepted.
- req_ready  out  N_REQ  one-hot, one-cycle accept pulse.
- req_base  in  N_REQ*ADDR_W  flattened ring bases; requester i at [i*ADDR_W +: ADDR_W].
- req_size  in  N_REQ*RING_W  flattened ring sizes.
- req_ctx  in  N_REQ*CTX_W  flattened context selects.
- submit_base  out  ADDR_W  to CAI host.
- submit_size  out  RING_W  to CAI host.
- context_sel  out  CTX_W  to CAI host.
- submit_doorbell  out  1  to CAI host.
- comp_irq  in  1  from CAI device, level.
- done_valid  out  1  one-cycle completion pulse.
- done_id  out  ID_W  requester index of the completed job.
- done_err  out  1  qualifies done_valid: zero-size or timeout.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: all outputs are 0; state is IDLE; RR pointer is 0.
- Reset is asynchronous. Asserting rst mid-job drops submit_doorbell combinationally-async to 0 and abandons the job with no done_valid.
- Every output is registered.
- FSM states: IDLE, SETUP, RING, WAIT, DONE.
- IDLE:
  - If any req_valid is high, pick the winner: the first set bit searching upward from ptr, wrapping.
  - Pulse req_ready[winner].
  - Latch base, size and ctx into submit_base, submit_size and context_sel. Latch the winner into done_id.
  - Set ptr = winner+1 mod N_REQ.
  - Go to SETUP. If the latched size is 0, go to DONE with done_err=1 and no doorbell.
- SETUP: hold config for 1 cycle, then go to RING.
- RING: submit_doorbell=1 for exactly 1 cycle, then go to WAIT.
- WAIT: on comp_irq sampled high, go to DONE with done_err=0.
- DONE: done_valid=1 for 1 cycle, then go to IDLE.
- Latency: accept in cycle T, doorbell in T+2, done_valid in the cycle after comp_irq is first seen in WAIT.
- submit_base, submit_size and context_sel change only in the IDLE accept cycle and are held otherwise, including after DONE. Config is therefore stable across the doorbell cycle and the cycle before it.
- comp_irq is ignored in IDLE, SETUP and RING (stale or early interrupts). It counts only in WAIT.
- A requester that drops req_valid before its accept is simply not served.
- req_valid sampled high in DONE is not accepted until the following IDLE cycle. Maximum throughput is one job per 5 cycles plus device latency.
- Fairness: a continuously requesting requester waits at most N_REQ-1 jobs.

Optional Feature:
- Macro: CARBON_CAI_SCHED_TIMEOUT_EN.
- Defined:
  - A ceil(log2(TIMEOUT_CYCLES+1))-bit counter clears on entry to WAIT and increments each WAIT cycle without comp_irq.
  - When it reaches TIMEOUT_CYCLES, go to DONE with done_err=1.
  - If comp_irq arrives in the same cycle as the terminal count, comp_irq wins and done_err=0.
- Not defined: no counter; WAIT exits only on comp_irq or reset; done_err is set only for zero-size jobs.

Test Plan:
- Single request: req_valid[2]=1, base=0x1000, size=64, ctx=5 -> req_ready=4'b0100 at T, doorbell at T+2 with submit_base=0x1000, size=64, context_sel=5; comp_irq at T+6 -> done_valid at T+7, done_id=2, done_err=0.
- Round-robin: all four requesters held valid, comp_irq returned 3 cycles after each doorbell -> grant order 0,1,2,3,0; each done_id matches its grant.
- Zero size: req_valid[1]=1, size=0 -> req_ready[1] pulse, no doorbell, done_valid next-next cycle with done_id=1, done_err=1.
- Stale interrupt: comp_irq held high from SETUP through RING, then low -> no done_valid until comp_irq rises again in WAIT; config is unchanged on the doorbell cycle and the cycle before it.
- Reset mid-job: rst asserted during RING -> submit_doorbell=0 immediately, busy=0, no done_valid; after release, requester 0 has priority.
- With CARBON_CAI_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=8, comp_irq never asserted -> done_valid with done_err=1 exactly 8 WAIT cycles after entering WAIT.
